// File: rtl/sram_port_driver_if.sv
// Bundle between sram_port_driver and its environment: request stream, response stream,
// the RW0 macro port and init_done. "slave" is the driver, "master" is requester plus macro.
interface sram_port_driver_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int MASK_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [MASK_W-1:0] req_wmask;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              sram_en;
   logic              sram_wmode;
   logic [ADDR_W-1:0] sram_addr;
   logic [MASK_W-1:0] sram_wmask;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
   logic              init_done;

   modport master (
      output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready, sram_rdata,
      input  req_ready, resp_valid, resp_data, sram_en, sram_wmode, sram_addr, sram_wmask,
             sram_wdata, init_done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready, sram_rdata,
      output req_ready, resp_valid, resp_data, sram_en, sram_wmode, sram_addr, sram_wmask,
             sram_wdata, init_done
   );
endinterface

// File: rtl/sram_port_driver.sv
// Valid/ready front end for a single-port RW0 SRAM with a 2-entry in-order read-response buffer.
// Define SRAM_INIT_CLEAR_EN to zero-fill the whole array after reset before accepting traffic.
module sram_port_driver #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int MASK_W = 4,
   parameter int DEPTH  = 1024
) (
   input  logic              clock,
   input  logic              reset,
   sram_port_driver_if.slave bus
);

`ifdef SRAM_INIT_CLEAR_EN
   localparam bit INIT_CLEAR = 1'b1;
`else
   localparam bit INIT_CLEAR = 1'b0;
`endif

   // state   | meaning
   // ST_INIT | clearing sweep, one zero write per cycle, requests blocked
   // ST_RUN  | normal request/response traffic
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam state_t          ST_RST    = INIT_CLEAR ? ST_INIT : ST_RUN;
   localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);

   state_t            st_q, st_d;
   logic              armed_q, armed_d;
   logic [ADDR_W-1:0] sweep_q, sweep_d;
   logic              init_done_q, init_done_d;
   logic              pending_q, pending_d;
   logic [1:0]        count_q, count_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] buf_q [2];
   logic [DATA_W-1:0] buf_d [2];

   logic              run;
   logic              pop;
   logic [2:0]        occ;
   logic              rd_room;
   logic              req_ready;
   logic              fire;
   logic              sram_en;
   logic              sram_wmode;
   logic [ADDR_W-1:0] sram_addr;
   logic [MASK_W-1:0] sram_wmask;
   logic [DATA_W-1:0] sram_wdata;

   // armed_q keeps every output quiet while reset is asserted and until the first edge after it.
   assign run       = armed_q && (st_q == ST_RUN);
   assign pop       = (count_q != 2'd0) && bus.resp_ready;
   assign occ       = 3'(count_q) + 3'(pending_q);
   assign rd_room   = occ < (3'd2 + 3'(pop));
   assign req_ready = run && (bus.req_write || rd_room);
   assign fire      = bus.req_valid && req_ready;

   always_comb begin
      st_d        = st_q;
      armed_d     = 1'b1;
      sweep_d     = sweep_q;
      init_done_d = init_done_q;
      pending_d   = fire && !bus.req_write;
      count_d     = count_q + 2'(pending_q) - 2'(pop);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      buf_d       = buf_q;
      sram_en     = 1'b0;
      sram_wmode  = 1'b0;
      sram_addr   = '0;
      sram_wmask  = '0;
      sram_wdata  = '0;

      if (armed_q && (st_q == ST_INIT)) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_addr  = sweep_q;
         sram_wmask = '1;
         sweep_d    = sweep_q + 1'b1;
         if (sweep_q == SWEEP_LAST) begin
            st_d        = ST_RUN;
            init_done_d = 1'b1;
            sweep_d     = '0;
         end
      end else if (fire) begin
         sram_en    = 1'b1;
         sram_wmode = bus.req_write;
         sram_addr  = bus.req_addr;
         sram_wmask = bus.req_wmask;
         sram_wdata = bus.req_wdata;
      end

      // Read data is only valid the cycle after the read was issued.
      if (pending_q) begin
         buf_d[wr_ptr_q] = bus.sram_rdata;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st_q        <= ST_RST;
         armed_q     <= 1'b0;
         sweep_q     <= '0;
         init_done_q <= ~INIT_CLEAR;
         pending_q   <= 1'b0;
         count_q     <= 2'd0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         buf_q[0]    <= '0;
         buf_q[1]    <= '0;
      end else begin
         st_q        <= st_d;
         armed_q     <= armed_d;
         sweep_q     <= sweep_d;
         init_done_q <= init_done_d;
         pending_q   <= pending_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         buf_q       <= buf_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = (count_q != 2'd0);
   assign bus.resp_data  = buf_q[rd_ptr_q];
   assign bus.sram_en    = sram_en;
   assign bus.sram_wmode = sram_wmode;
   assign bus.sram_addr  = sram_addr;
   assign bus.sram_wmask = sram_wmask;
   assign bus.sram_wdata = sram_wdata;
   assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_sram_port_driver.sv
// Directed bench for sram_port_driver with a behavioural RW0 macro, a golden memory model
// and a response scoreboard. Covers the SRAM_INIT_CLEAR_EN sweep when that macro is defined.
module tb_sram_port_driver;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;
   localparam int DEPTH  = 1024;
   localparam int LANE   = DATA_W / MASK_W;

`ifdef SRAM_INIT_CLEAR_EN
   localparam logic INIT_RST_EXP = 1'b0;
`else
   localparam logic INIT_RST_EXP = 1'b1;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   sram_port_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

   sram_port_driver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   logic [DATA_W-1:0] sram_mem [DEPTH];
   logic [DATA_W-1:0] ref_mem  [DEPTH];
   logic [DATA_W-1:0] exp_q [$];
   int                resp_cyc_q [$];
   logic [DATA_W-1:0] exp_v;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural RW0 macro: registered read, masked write, garbage on rdata when not reading.
   always @(posedge clock) begin
      if (bus.sram_en && !bus.sram_wmode) bus.sram_rdata <= sram_mem[bus.sram_addr];
      else                                bus.sram_rdata <= $urandom;
      if (bus.sram_en && bus.sram_wmode)
         for (int l = 0; l < MASK_W; l++)
            if (bus.sram_wmask[l]) sram_mem[bus.sram_addr][l*LANE +: LANE] <= bus.sram_wdata[l*LANE +: LANE];
   end

   always @(negedge clock) begin
      if (!reset && bus.resp_valid && bus.resp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL resp_unexpected: observed data %h, required no response", bus.resp_data);
            end
         end else begin
            exp_v = exp_q.pop_front();
            resp_cyc_q.push_back(cyc);
            assert (bus.resp_data === exp_v) else begin
               errors++;
               $error("FAIL resp_data: observed %h, required %h", bus.resp_data, exp_v);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, required %h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic req(input logic w, input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m,
                      input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wmask = m;
      bus.req_wdata = d;
      @(negedge clock);
      while (!bus.req_ready && n < 50) begin
         n++;
         @(negedge clock);
      end
      chk("req_accept", 32'(bus.req_ready), 32'd1);
      if (bus.req_ready) begin
         chk("sram_drive", 32'({bus.sram_en, bus.sram_wmode, bus.sram_addr}), 32'({1'b1, w, a}));
         last_acc_cyc = cyc;
         if (w) begin
            chk("sram_wdata", bus.sram_wdata, d);
            for (int l = 0; l < MASK_W; l++)
               if (m[l]) ref_mem[a][l*LANE +: LANE] = d[l*LANE +: LANE];
         end else begin
            exp_q.push_back(exp_rd);
         end
      end
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
      req(1'b1, a, m, d, '0);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
      req(1'b0, a, '0, '0, e);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus.resp_valid) && n < 50) begin
         n++;
         @(negedge clock);
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      int n;
      int bad;
      int first_acc;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wmask  = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_sram_en", 32'(bus.sram_en), 32'd0);
      chk("rst_init_done", 32'(bus.init_done), 32'(INIT_RST_EXP));
      @(posedge clock);
      #1 reset = 1'b0;

`ifdef SRAM_INIT_CLEAR_EN
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(bus.sram_en && bus.sram_addr == 10'd500) && n < 2000);
      chk("sweep_reach_500", 32'(bus.sram_addr), 32'd500);
      reset = 1'b1;
      #1;
      chk("midsweep_init_done", 32'(bus.init_done), 32'd0);
      chk("midsweep_sram_en", 32'(bus.sram_en), 32'd0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.sram_en && n < 10);
      chk("sweep_restart_addr", 32'({bus.sram_en, bus.sram_addr}), 32'({1'b1, 10'd0}));
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i > 0) @(negedge clock);
         if (!(bus.sram_en && bus.sram_wmode && bus.sram_addr == 10'(i) && bus.sram_wmask == 4'hF &&
               bus.sram_wdata == 32'h0 && !bus.init_done && !bus.req_ready)) bad++;
      end
      chk("sweep_bad_cycles", 32'(bad), 32'd0);
      @(negedge clock);
      chk("init_done_after_sweep", 32'(bus.init_done), 32'd1);
      chk("sweep_stopped", 32'(bus.sram_en), 32'd0);
      chk("run_req_ready", 32'(bus.req_ready), 32'd1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      @(posedge clock);
      #1;
      rd(10'h3FF, 32'h0000_0000);
`else
      @(posedge clock);
      @(negedge clock);
      chk("run_init_done", 32'(bus.init_done), 32'd1);
      chk("run_req_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clock);
      #1;
`endif

      @(negedge clock);
      chk("idle_sram_hold", 32'({bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask}), 32'd0);
      @(posedge clock);
      #1;

      // Masked write merge
      wr(10'h005, 4'hF, 32'hDEAD_BEEF);
      wr(10'h005, 4'h2, 32'h1122_3344);
      rd(10'h005, 32'hDEAD_33EF);
      drain();

      // Streaming reads
      for (int a = 16; a < 24; a++) wr(10'(a), 4'hF, 32'(a));
      drain();
      resp_cyc_q.delete();
      first_acc = 0;
      for (int i = 0; i < 8; i++) begin
         rd(10'(16 + i), 32'(16 + i));
         if (i == 0) first_acc = last_acc_cyc;
      end
      drain();
      chk("stream_resp_count", 32'(resp_cyc_q.size()), 32'd8);
      if (resp_cyc_q.size() == 8) begin
         chk("stream_first_latency", 32'(resp_cyc_q[0] - first_acc), 32'd2);
         bad = 0;
         for (int i = 1; i < 8; i++) if (resp_cyc_q[i] != resp_cyc_q[0] + i) bad++;
         chk("stream_consecutive", 32'(bad), 32'd0);
      end

      // Backpressure
      bus.resp_ready = 1'b0;
      rd(10'h010, 32'h10);
      rd(10'h011, 32'h11);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 10'h012;
      @(negedge clock);
      chk("bp_read_blocked_1", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
      chk("bp_read_blocked_2", 32'(bus.req_ready), 32'd0);
      chk("bp_head_held", {31'd0, bus.resp_valid} ^ bus.resp_data, 32'h11);
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      wr(10'h030, 4'hF, 32'hCAFE_F00D);
      bus.resp_ready = 1'b1;
      rd(10'h012, 32'h12);
      drain();

      // Write after read returns old data; read after write returns new
      wr(10'h020, 4'hF, 32'hAAAA_5555);
      rd(10'h020, 32'hAAAA_5555);
      wr(10'h020, 4'hF, 32'h1234_5678);
      rd(10'h020, 32'h1234_5678);
      drain();
      chk("war_ref_model", ref_mem[10'h020], 32'h1234_5678);

      // Reset with reads outstanding discards them
      bus.resp_ready = 1'b0;
      rd(10'h010, 32'h10);
      rd(10'h011, 32'h11);
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_discard_resp_valid", 32'(bus.resp_valid), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      bus.resp_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.init_done && n < 1100);
      @(negedge clock);
      @(negedge clock);
      chk("rst_discard_after", 32'({bus.init_done, bus.resp_valid}), 32'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
